// File: rtl/eth_gmii_tx_framer.sv
`default_nettype none
// ============================================================================
// Module      : eth_gmii_tx_framer
// Description : Transmit-side GMII framer, clk250_i domain. Takes raw frame
//               bytes (DA through payload) on a valid/ready/last byte stream
//               and produces a 125 Mbyte/s GMII stream: 7x preamble, SFD,
//               data, zero pad up to min_frame_p, FCS (CRC-32), then
//               ifg_bytes_p idle byte-times.
// Revision    : 1.0 - initial release
// ----------------------------------------------------------------------------
// Ports
//   clk250_i      in   250 MHz clock, rising edge
//   reset_r_lo    in   asynchronous active-high reset
//   data_i        in   frame byte
//   data_valid_i  in   data_i valid
//   data_last_i   in   data_i is the final frame byte
//   data_ready_o  out  byte consumed when data_valid_i & data_ready_o
//   gmii_txd_o    out  GMII transmit byte (registered)
//   gmii_tx_en_o  out  GMII transmit enable (registered)
//   gmii_tx_er_o  out  GMII transmit error (registered)
//   byte_tick_o   out  high on cycles at whose end the GMII outputs load
//   busy_o        out  framer not idle
//   tx_done_o     out  pulse on the tick that loads the last FCS byte
//   underrun_o    out  pulse on the tick that loads the underrun error byte
// ============================================================================
module eth_gmii_tx_framer #(
    parameter int min_frame_p = 60,
    parameter int ifg_bytes_p = 12
) (
    input  logic       clk250_i,
    input  logic       reset_r_lo,
    input  logic [7:0] data_i,
    input  logic       data_valid_i,
    input  logic       data_last_i,
    output logic       data_ready_o,
    output logic [7:0] gmii_txd_o,
    output logic       gmii_tx_en_o,
    output logic       gmii_tx_er_o,
    output logic       byte_tick_o,
    output logic       busy_o,
    output logic       tx_done_o,
    output logic       underrun_o
);

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_PRE  = 3'd1,
        ST_SFD  = 3'd2,
        ST_DATA = 3'd3,
        ST_PAD  = 3'd4,
        ST_FCS  = 3'd5,
        ST_DROP = 3'd6,
        ST_IFG  = 3'd7
    } state_t;

    localparam logic [11:0] min_len  = 12'(min_frame_p);
    // IFG leaves on the tick where cnt reaches ifg_last; a zero gap still
    // costs one idle byte-time.
    localparam logic [10:0] ifg_last = (ifg_bytes_p > 1) ? 11'(ifg_bytes_p - 1) : 11'd0;

    state_t      state_r, state_nx;
    logic        phase_r;
    logic [10:0] cnt_r, cnt_nx;
    logic [10:0] len_r, len_nx;
    logic [31:0] crc_r, crc_nx;
    logic [7:0]  txd_nx;
    logic        tx_en_nx, tx_er_nx;
    logic        tick;
    logic [11:0] len_plus1;
    logic [10:0] len_sat;
    logic [31:0] fcs;

    // Reflected CRC-32, one byte per call, LSB first.
    function automatic logic [31:0] crc_step(input logic [31:0] crc, input logic [7:0] d);
        logic [31:0] c;
        c = crc ^ {24'd0, d};
        for (int i = 0; i < 8; i++) begin
            c = c[0] ? ((c >> 1) ^ 32'hEDB88320) : (c >> 1);
        end
        return c;
    endfunction

    assign tick        = phase_r;
    assign byte_tick_o = phase_r;
    assign busy_o      = (state_r != ST_IDLE);
    assign len_plus1   = {1'b0, len_r} + 12'd1;
    assign len_sat     = (len_r == 11'h7FF) ? len_r : len_r + 11'd1;
    assign fcs         = ~crc_r;

    always_comb begin
        state_nx     = state_r;
        cnt_nx       = cnt_r;
        len_nx       = len_r;
        crc_nx       = crc_r;
        txd_nx       = 8'h00;
        tx_en_nx     = 1'b0;
        tx_er_nx     = 1'b0;
        data_ready_o = 1'b0;
        tx_done_o    = 1'b0;
        underrun_o   = 1'b0;
        case (state_r)
            ST_IDLE: begin
                // The waiting byte is only looked at, not consumed, here.
                if (data_valid_i) begin
                    txd_nx   = 8'h55;
                    tx_en_nx = 1'b1;
                    cnt_nx   = 11'd1;
                    state_nx = ST_PRE;
                end
            end
            ST_PRE: begin
                txd_nx   = 8'h55;
                tx_en_nx = 1'b1;
                cnt_nx   = cnt_r + 11'd1;
                if (cnt_r == 11'd6) state_nx = ST_SFD;
            end
            ST_SFD: begin
                txd_nx   = 8'hD5;
                tx_en_nx = 1'b1;
                len_nx   = 11'd0;
                crc_nx   = 32'hFFFF_FFFF;
                state_nx = ST_DATA;
            end
            ST_DATA: begin
                data_ready_o = tick;
                tx_en_nx     = 1'b1;
                if (data_valid_i) begin
                    txd_nx = data_i;
                    crc_nx = crc_step(crc_r, data_i);
                    len_nx = len_sat;
                    if (data_last_i) begin
                        cnt_nx   = 11'd0;
                        state_nx = (len_plus1 < min_len) ? ST_PAD : ST_FCS;
                    end
                end else begin
                    // Starved mid-frame: one error byte, then drain and abort.
                    tx_er_nx   = 1'b1;
                    underrun_o = tick;
                    state_nx   = ST_DROP;
                end
            end
            ST_PAD: begin
                tx_en_nx = 1'b1;
                crc_nx   = crc_step(crc_r, 8'h00);
                len_nx   = len_sat;
                if (len_plus1 >= min_len) begin
                    cnt_nx   = 11'd0;
                    state_nx = ST_FCS;
                end
            end
            ST_FCS: begin
                txd_nx   = 8'(fcs >> {cnt_r[1:0], 3'b000});
                tx_en_nx = 1'b1;
                cnt_nx   = cnt_r + 11'd1;
                if (cnt_r == 11'd3) begin
                    tx_done_o = tick;
                    cnt_nx    = 11'd0;
                    state_nx  = ST_IFG;
                end
            end
            ST_DROP: begin
                data_ready_o = tick;
                if (data_valid_i && data_last_i) begin
                    cnt_nx   = 11'd0;
                    state_nx = ST_IFG;
                end
            end
            ST_IFG: begin
                cnt_nx = cnt_r + 11'd1;
                if (cnt_r >= ifg_last) state_nx = ST_IDLE;
            end
            default: state_nx = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk250_i or posedge reset_r_lo) begin
        if (reset_r_lo) begin
            phase_r      <= 1'b0;
            state_r      <= ST_IDLE;
            cnt_r        <= 11'd0;
            len_r        <= 11'd0;
            crc_r        <= 32'hFFFF_FFFF;
            gmii_txd_o   <= 8'h00;
            gmii_tx_en_o <= 1'b0;
            gmii_tx_er_o <= 1'b0;
        end else begin
            phase_r <= ~phase_r;
            // Everything else advances at the byte rate only.
            if (tick) begin
                state_r      <= state_nx;
                cnt_r        <= cnt_nx;
                len_r        <= len_nx;
                crc_r        <= crc_nx;
                gmii_txd_o   <= txd_nx;
                gmii_tx_en_o <= tx_en_nx;
                gmii_tx_er_o <= tx_er_nx;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_eth_gmii_tx_framer.sv
`default_nettype none
// ============================================================================
// Module      : tb_eth_gmii_tx_framer
// Description : Self-checking bench for eth_gmii_tx_framer. Two instances:
//               index 0 pads to 60 bytes, index 1 has padding disabled.
//               Wire bytes are captured once per byte-time and compared
//               against a frame-level reference model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_eth_gmii_tx_framer;

    logic clk = 1'b0;
    always #2 clk = ~clk;

    logic       rst;
    logic [7:0] din [2];
    logic [1:0] dval, dlast;
    wire  [1:0] rdy, txen, txer, tck, bsy, dn, urn;
    wire  [15:0] txd;

    eth_gmii_tx_framer #(.min_frame_p(60), .ifg_bytes_p(12)) u_dut0 (
        .clk250_i(clk), .reset_r_lo(rst),
        .data_i(din[0]), .data_valid_i(dval[0]), .data_last_i(dlast[0]),
        .data_ready_o(rdy[0]), .gmii_txd_o(txd[7:0]), .gmii_tx_en_o(txen[0]),
        .gmii_tx_er_o(txer[0]), .byte_tick_o(tck[0]), .busy_o(bsy[0]),
        .tx_done_o(dn[0]), .underrun_o(urn[0])
    );

    eth_gmii_tx_framer #(.min_frame_p(0), .ifg_bytes_p(12)) u_dut1 (
        .clk250_i(clk), .reset_r_lo(rst),
        .data_i(din[1]), .data_valid_i(dval[1]), .data_last_i(dlast[1]),
        .data_ready_o(rdy[1]), .gmii_txd_o(txd[15:8]), .gmii_tx_en_o(txen[1]),
        .gmii_tx_er_o(txer[1]), .byte_tick_o(tck[1]), .busy_o(bsy[1]),
        .tx_done_o(dn[1]), .underrun_o(urn[1])
    );

    int n_cmp = 0;
    int n_fail = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] req);
        n_cmp++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %0h required %0h", nm, act, req);
        end
    endtask

    // ---------------- wire monitor: one sample {en,er,txd} per byte-time ----
    logic [9:0] cap [2][$];
    int         done_cnt [2];
    int         ur_cnt [2];
    logic [9:0] prev_o [2];
    logic       prev_t [2];
    bit         prev_v [2];

    initial begin
        for (int d = 0; d < 2; d++) begin
            done_cnt[d] = 0; ur_cnt[d] = 0; prev_v[d] = 0;
        end
    end

    always @(negedge clk) begin
        for (int d = 0; d < 2; d++) begin
            logic [9:0] o;
            logic       t;
            logic       bad;
            o = {txen[d], txer[d], txd[8*d +: 8]};
            t = tck[d];
            if (rst) begin
                prev_v[d] = 0;
            end else begin
                if (prev_v[d]) begin
                    // tick must alternate; outputs may only move after a tick;
                    // handshake/pulses only on tick cycles
                    bad = (t == prev_t[d]) || (!prev_t[d] && (o != prev_o[d])) ||
                          (!t && (rdy[d] || dn[d] || urn[d]));
                    chk($sformatf("tick_alignment%0d", d), {63'd0, bad}, 64'd0);
                end
                if (!t) cap[d].push_back(o);
                else begin
                    if (dn[d])  done_cnt[d]++;
                    if (urn[d]) ur_cnt[d]++;
                end
                prev_o[d] = o; prev_t[d] = t; prev_v[d] = 1;
            end
        end
    end

    // ---------------- reference model --------------------------------------
    logic [7:0] frame [$];
    logic [9:0] expq [$];
    logic [9:0] got [$];
    int         gap_got;
    int         exp_done [2];

    task automatic build_exp(input int minf, input int ur_idx);
        logic [7:0]  msg [$];
        logic [31:0] c;
        expq.delete();
        repeat (7) expq.push_back(10'h255);
        expq.push_back(10'h2D5);
        if (ur_idx >= 0) begin
            for (int i = 0; i < ur_idx; i++) expq.push_back({2'b10, frame[i]});
            expq.push_back(10'h300);
            return;
        end
        msg = frame;
        while (msg.size() < minf) msg.push_back(8'h00);
        c = 32'hFFFF_FFFF;
        for (int i = 0; i < msg.size() * 8; i++)
            c = (c >> 1) ^ (((c[0] ^ msg[i/8][i%8]) != 1'b0) ? 32'hEDB88320 : 32'h0);
        c = ~c;
        foreach (msg[i]) expq.push_back({2'b10, msg[i]});
        for (int j = 0; j < 4; j++) expq.push_back({2'b10, c[8*j +: 8]});
    endtask

    // ---------------- drivers / collectors ----------------------------------
    task automatic push_byte(input int d, input logic [7:0] b, input logic l, output int k);
        din[d] = b; dval[d] = 1'b1; dlast[d] = l; k = 0;
        do begin @(negedge clk); k++; end while (!rdy[d] && k < 400);
        if (!rdy[d]) chk("ready_timeout", {63'd0, rdy[d]}, 64'd1);
        @(posedge clk); #1;
    endtask

    task automatic send_frame(input int d, input bit hold);
        int k;
        for (int i = 0; i < frame.size(); i++)
            push_byte(d, frame[i], (i == frame.size() - 1), k);
        if (!hold) begin dval[d] = 1'b0; dlast[d] = 1'b0; end
    endtask

    task automatic get_run(input int d);
        int k;
        k = 0; got.delete(); gap_got = 0;
        while (k < 2000) begin
            if (cap[d].size() == 0) begin @(negedge clk); k++; end
            else if (cap[d][0][9]) break;
            else begin void'(cap[d].pop_front()); gap_got++; end
        end
        while (k < 2000) begin
            if (cap[d].size() == 0) begin @(negedge clk); k++; end
            else if (!cap[d][0][9]) break;
            else got.push_back(cap[d].pop_front());
        end
        if (k >= 2000) chk("run_timeout", 64'(k), 64'd0);
    endtask

    task automatic check_run(input int d, input int minf, input int ur_idx, input string nm);
        int bad;
        build_exp(minf, ur_idx);
        get_run(d);
        chk({nm, "_en_len"}, 64'(got.size()), 64'(expq.size()));
        bad = -1;
        for (int i = 0; i < got.size() && i < expq.size(); i++)
            if (bad < 0 && got[i] !== expq[i]) bad = i;
        if (bad >= 0) $display("  %s byte %0d: got %h required %h", nm, bad, got[bad], expq[bad]);
        chk({nm, "_first_bad_byte"}, 64'(bad), 64'(-1));
    endtask

    // ---------------- directed vector table ---------------------------------
    typedef struct {
        int         d;
        int         len;
        logic [7:0] first;
        int         en_ticks;
        logic [31:0] fcs;
    } vec_t;

    vec_t vt [6];

    initial begin
        int k, lat, n, d, b2b_gap;
        logic [7:0] fa [$];
        logic [7:0] fb [$];

        vt[0] = '{d:1, len:9,  first:8'h31, en_ticks:21, fcs:32'hCBF43926};
        vt[1] = '{d:0, len:1,  first:8'hAA, en_ticks:72, fcs:32'h0};
        vt[2] = '{d:0, len:60, first:8'h00, en_ticks:72, fcs:32'h0};
        vt[3] = '{d:0, len:61, first:8'h10, en_ticks:73, fcs:32'h0};
        vt[4] = '{d:1, len:1,  first:8'h5A, en_ticks:13, fcs:32'h0};
        vt[5] = '{d:0, len:59, first:8'h80, en_ticks:72, fcs:32'h0};
        exp_done[0] = 0; exp_done[1] = 0;

        rst = 1'b1; dval = '0; dlast = '0; din[0] = 8'h00; din[1] = 8'h00;
        repeat (3) @(posedge clk);
        #1;
        chk("reset_outputs", {34'd0, txd, txen, txer, tck, bsy, dn, urn, rdy}, 64'd0);
        rst = 1'b0;
        chk("phase_after_release", {62'd0, tck}, 64'd0);

        // table-driven frames
        for (int i = 0; i < 6; i++) begin
            frame.delete();
            for (int j = 0; j < vt[i].len; j++) frame.push_back(vt[i].first + 8'(j));
            send_frame(vt[i].d, 0);
            check_run(vt[i].d, (vt[i].d == 0) ? 60 : 0, -1, $sformatf("vec%0d", i));
            chk($sformatf("vec%0d_en_ticks", i), 64'(got.size()), 64'(vt[i].en_ticks));
            n = got.size();
            if (vt[i].fcs != 32'h0 && n >= 4)
                chk($sformatf("vec%0d_fcs", i),
                    {32'd0, got[n-1][7:0], got[n-2][7:0], got[n-3][7:0], got[n-4][7:0]},
                    {32'd0, vt[i].fcs});
            exp_done[vt[i].d]++;
            chk($sformatf("vec%0d_done", i), 64'(done_cnt[vt[i].d]), 64'(exp_done[vt[i].d]));
        end

        // random frames on both instances
        for (int r = 0; r < 16; r++) begin
            d = r % 2;
            frame.delete();
            n = $urandom_range(1, 100);
            for (int j = 0; j < n; j++) frame.push_back(8'($urandom));
            repeat ($urandom_range(0, 6)) @(posedge clk);
            #1;
            send_frame(d, 0);
            check_run(d, (d == 0) ? 60 : 0, -1, $sformatf("rnd%0d", r));
            exp_done[d]++;
            chk($sformatf("rnd%0d_done", r), 64'(done_cnt[d]), 64'(exp_done[d]));
        end

        // two back-to-back 64-byte frames with valid held high
        fa.delete(); fb.delete();
        for (int j = 0; j < 64; j++) begin fa.push_back(8'($urandom)); fb.push_back(8'($urandom)); end
        frame = fa; send_frame(0, 1);
        frame = fb; send_frame(0, 0);
        frame = fa; check_run(0, 60, -1, "b2b_a");
        frame = fb; check_run(0, 60, -1, "b2b_b");
        b2b_gap = gap_got;
        chk("b2b_ifg_ticks", 64'(b2b_gap), 64'd12);
        exp_done[0] += 2;
        chk("b2b_done", 64'(done_cnt[0]), 64'(exp_done[0]));

        // underrun at the 5th byte of a 20-byte frame
        frame.delete();
        for (int j = 0; j < 20; j++) frame.push_back(8'h40 + 8'(j));
        for (int j = 0; j < 4; j++) push_byte(0, frame[j], 1'b0, k);
        dval[0] = 1'b0;
        k = 0;
        do begin @(negedge clk); k++; end while (!tck[0] && k < 4);
        chk("underrun_pulse", {63'd0, urn[0]}, 64'd1);
        @(posedge clk); #1;
        for (int j = 4; j < 20; j++) push_byte(0, frame[j], (j == 19), k);
        dval[0] = 1'b0; dlast[0] = 1'b0;
        k = 0;
        while (k < 100) begin @(negedge clk); if (!bsy[0]) break; k++; end
        chk("underrun_ifg_cycles", 64'(k), 64'd24);
        check_run(0, 60, 4, "underrun");
        chk("underrun_no_done", 64'(done_cnt[0]), 64'(exp_done[0]));
        chk("underrun_count0", 64'(ur_cnt[0]), 64'd1);
        chk("underrun_count1", 64'(ur_cnt[1]), 64'd0);

        // reset in the middle of the FCS
        frame.delete();
        for (int j = 0; j < 60; j++) frame.push_back(8'($urandom));
        send_frame(0, 0);
        repeat (3) @(posedge clk);
        #1;
        chk("fcs_phase_active", {63'd0, txen[0]}, 64'd1);
        rst = 1'b1;
        #1;
        chk("async_reset_outputs", {50'd0, txd[7:0], txen[0], txer[0], bsy[0], rdy[0], dn[0], urn[0]}, 64'd0);
        repeat (2) @(posedge clk);
        #1;
        cap[0].delete(); cap[1].delete();
        rst = 1'b0;
        chk("phase_after_midframe_reset", {62'd0, tck[0], bsy[0]}, 64'd0);
        chk("no_done_on_reset", 64'(done_cnt[0]), 64'(exp_done[0]));

        // fresh 60-byte frame started on a tick: first byte consumed 16 cycles later
        k = 0;
        do begin @(negedge clk); k++; end while (!tck[0] && k < 10);
        frame.delete();
        for (int j = 0; j < 60; j++) frame.push_back(8'($urandom));
        push_byte(0, frame[0], 1'b0, lat);
        chk("start_latency", 64'(lat), 64'd16);
        for (int j = 1; j < 60; j++) push_byte(0, frame[j], (j == 59), k);
        dval[0] = 1'b0; dlast[0] = 1'b0;
        check_run(0, 60, -1, "post_reset");
        exp_done[0]++;
        chk("post_reset_done", 64'(done_cnt[0]), 64'(exp_done[0]));

        repeat (4) @(posedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

    initial begin
        #1000000;
        n_fail++;
        $display("FAIL watchdog: got timeout required completion");
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $fatal(1, "watchdog");
    end

endmodule
`default_nettype wire
